// File: rtl/nn_pkg.sv
// Shared defaults, saturation limits and value types for the neuron datapath
// and the ReLU/requantization buffer that follows it.
package nn_pkg;

  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int N_OUT = 20;
  localparam int SHIFT = 8;

  localparam int OUT_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] act_t;

endpackage

// File: rtl/relu_requant_buffer_if.sv
// Serial sum input link and packed result vector output of relu_requant_buffer.
// master = sum producer / vector consumer, slave = the buffer itself.
interface relu_requant_buffer_if
  import nn_pkg::*;
#(
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int OUT_W = nn_pkg::OUT_W,
  parameter int N_OUT = nn_pkg::N_OUT
) ();

  logic                   acc_valid;
  logic                   acc_ready;
  logic [ACC_W-1:0]       acc_data;
  logic                   vec_valid;
  logic                   vec_ack;
  logic [N_OUT*OUT_W-1:0] vec_data;

  modport master (
    output acc_valid,
    output acc_data,
    output vec_ack,
    input  acc_ready,
    input  vec_valid,
    input  vec_data
  );

  modport slave (
    input  acc_valid,
    input  acc_data,
    input  vec_ack,
    output acc_ready,
    output vec_valid,
    output vec_data
  );

endinterface

// File: rtl/relu_requant_core.sv
// Combinational datapath for one value: activation (ReLU, or leaky ReLU when
// LEAKY_RELU_EN is defined) and round / arithmetic shift / saturate to OUT_W.
module relu_requant_core
  import nn_pkg::*;
#(
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int OUT_W = nn_pkg::OUT_W,
  parameter int SHIFT = nn_pkg::SHIFT
) (
  input  logic signed [ACC_W-1:0] i_x,
  output logic signed [ACC_W-1:0] o_act,
  input  logic signed [ACC_W-1:0] i_a,
  output logic signed [OUT_W-1:0] o_y
);

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-(2 ** (OUT_W - 1)));

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shr;

  // Leaky slope of 1/8 is a floor shift, so small negatives settle at -1, not 0
  always_comb begin
`ifdef LEAKY_RELU_EN
    o_act = i_x[ACC_W-1] ? (i_x >>> 3) : i_x;
`else
    o_act = i_x[ACC_W-1] ? '0 : i_x;
`endif
  end

  // One guard bit so the rounding add on the largest positive sum stays positive
  always_comb begin
    w_ext = {i_a[ACC_W-1], i_a};
    w_sum = w_ext + RND;
    w_shr = w_sum >>> SHIFT;
    if (w_shr > SAT_MAX) begin
      o_y = OUT_W'(SAT_MAX);
    end else if (w_shr < SAT_MIN) begin
      o_y = OUT_W'(SAT_MIN);
    end else begin
      o_y = OUT_W'(w_shr);
    end
  end

endmodule

// File: rtl/relu_requant_buffer.sv
// Collects N_OUT serial neuron sums, activates and requantizes each one, and
// presents them as one packed vector for the next layer. Option: LEAKY_RELU_EN.
module relu_requant_buffer
  import nn_pkg::*;
#(
  parameter int N_OUT = nn_pkg::N_OUT,
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int OUT_W = nn_pkg::OUT_W,
  parameter int SHIFT = nn_pkg::SHIFT
) (
  input logic                  clk,
  input logic                  rst,
  relu_requant_buffer_if.slave bus
);

  localparam int CW = $clog2(N_OUT + 1);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [CW-1:0]           r_accCnt;
  logic [IW-1:0]           r_wrIdx;
  logic                    r_accReady;
  logic                    r_vecValid;
  logic                    r_s1Valid;
  logic signed [ACC_W-1:0] r_s1Act;
  logic [N_OUT*OUT_W-1:0]  r_vecData;

  logic                    w_xfer;
  logic                    w_lastWrite;
  logic [CW-1:0]           w_accCntNext;
  logic                    w_vecValidNext;
  logic signed [ACC_W-1:0] w_act;
  logic signed [OUT_W-1:0] w_y;

  relu_requant_core #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .i_x   (bus.acc_data),
    .o_act (w_act),
    .i_a   (r_s1Act),
    .o_y   (w_y)
  );

  assign w_xfer      = bus.acc_valid && r_accReady;
  assign w_lastWrite = r_s1Valid && (r_wrIdx == IW'(N_OUT - 1));

  // The last write never coincides with a transfer: acc_cnt is already full then
  always_comb begin
    w_accCntNext   = r_accCnt;
    w_vecValidNext = r_vecValid;
    if (w_lastWrite) begin
      w_accCntNext   = '0;
      w_vecValidNext = 1'b1;
    end else begin
      if (w_xfer) begin
        w_accCntNext = r_accCnt + 1'b1;
      end
      if (r_vecValid && bus.vec_ack) begin
        w_vecValidNext = 1'b0;
      end
    end
  end

  // Ready is registered from next-state values, so acc_valid never reaches it combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accCnt   <= '0;
      r_wrIdx    <= '0;
      r_accReady <= 1'b0;
      r_vecValid <= 1'b0;
      r_s1Valid  <= 1'b0;
      r_s1Act    <= '0;
      r_vecData  <= '0;
    end else begin
      r_accCnt   <= w_accCntNext;
      r_vecValid <= w_vecValidNext;
      r_accReady <= !w_vecValidNext && (w_accCntNext < CW'(N_OUT));
      r_s1Valid  <= w_xfer;
      if (w_xfer) begin
        r_s1Act <= w_act;
      end
      if (r_s1Valid) begin
        r_vecData[int'(r_wrIdx) * OUT_W +: OUT_W] <= w_y;
        r_wrIdx <= w_lastWrite ? '0 : r_wrIdx + 1'b1;
      end
    end
  end

  assign bus.acc_ready = r_accReady;
  assign bus.vec_valid = r_vecValid;
  assign bus.vec_data  = r_vecData;

endmodule

// File: tb/tb_relu_requant_buffer.sv
// Self-checking bench for relu_requant_buffer: table-driven vectors plus a
// scoreboard queue popped whenever a completed vector appears.
module tb_relu_requant_buffer;
  import nn_pkg::*;

  typedef logic [N_OUT*OUT_W-1:0] vec_t;
  typedef struct {
    acc_t x;
    act_t want;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  relu_requant_buffer_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .N_OUT(N_OUT)) bus ();

  relu_requant_buffer #(
    .N_OUT (N_OUT),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   checks    = 0;
  int   passes    = 0;
  int   vecCount  = 0;
  bit   prevVV    = 1'b0;
  act_t expQ[$];

  task automatic checkOutput(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic checkVec(input string name, input vec_t got, input vec_t want);
    checks++;
    if (got == want) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
  endtask

  function automatic vec_rec_t mk(input longint x, input longint want);
    vec_rec_t r;
    r.x    = acc_t'(x);
    r.want = act_t'(want);
    return r;
  endfunction

  // Drive one sum; the expected element is queued once the transfer is certain
  task automatic applyStimulus(input longint x, input longint want);
    int waited = 0;
    bus.acc_valid = 1'b1;
    bus.acc_data  = acc_t'(x);
    while (!bus.acc_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.acc_ready) begin
      checks++;
      $display("[TB] FAIL send_timeout: acc_ready got 0 for 64 cycles, expected 1");
      bus.acc_valid = 1'b0;
    end else begin
      expQ.push_back(act_t'(want));
      @(negedge clk);
    end
  endtask

  task automatic waitVec(input string name);
    int n = 0;
    while (!bus.vec_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, longint'(bus.vec_valid), 1);
  endtask

  task automatic ackVector(input string name);
    checkOutput({name, "_rdy_before"}, longint'(bus.acc_ready), 0);
    bus.vec_ack = 1'b1;
    @(negedge clk);
    bus.vec_ack = 1'b0;
    checkOutput({name, "_vv_after"}, longint'(bus.vec_valid), 0);
    checkOutput({name, "_rdy_after"}, longint'(bus.acc_ready), 1);
  endtask

  // Scoreboard: every newly completed vector is compared element by element
  always @(negedge clk) begin : monitor
    act_t got;
    act_t want;
    if (bus.vec_valid && !prevVV) begin
      vecCount++;
      for (int i = 0; i < N_OUT; i++) begin
        got = act_t'(bus.vec_data[i*OUT_W +: OUT_W]);
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL vec%0d_e%0d: got %0d, expected a queued value (none left)",
                   vecCount, i, got);
        end else begin
          want = expQ.pop_front();
          checkOutput($sformatf("vec%0d_e%0d", vecCount, i), longint'(got), longint'(want));
        end
      end
    end
    prevVV = bus.vec_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_rec_t recs[40];
    vec_t     stallVec;
    act_t     e0;

    recs[0] = mk(-5000, 0);
    recs[1] = mk(2147483647, 32767);
    recs[2] = mk(127, 0);
    recs[3] = mk(128, 1);
    for (int i = 4; i < 20; i++) recs[i] = mk(0, 0);
    recs[20] = mk(383, 1);
    recs[21] = mk(384, 2);
    recs[22] = mk(8388352, 32767);
    recs[23] = mk(8388480, 32767);
    recs[24] = mk(-1, 0);
    recs[25] = mk(-64'sd2147483648, 0);
    recs[26] = mk(640, 3);
    recs[27] = mk(639, 2);
    for (int k = 8; k < 20; k++) recs[20 + k] = mk(longint'(k) * 256, k);
`ifdef LEAKY_RELU_EN
    recs[0]  = mk(-5000, -2);
    recs[25] = mk(-64'sd2147483648, OUT_MIN);
`endif

    rst = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    bus.vec_ack   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rdy", longint'(bus.acc_ready), 0);
    checkOutput("reset_vv", longint'(bus.vec_valid), 0);
    checkVec("reset_data", bus.vec_data, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_rdy", longint'(bus.acc_ready), 1);

    $display("[TB] basic back-to-back vector");
    for (int k = 0; k < N_OUT; k++) applyStimulus(4736, 19);
    bus.acc_valid = 1'b0;
    checkOutput("t1_vv_t+1", longint'(bus.vec_valid), 0);
    @(negedge clk);
    checkOutput("t1_vv_t+2", longint'(bus.vec_valid), 1);
    ackVector("t1");

    $display("[TB] sign, rounding and saturation tables");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(longint'(recs[i].x), longint'(recs[i].want));
      if (i % 20 == 19) begin
        bus.acc_valid = 1'b0;
        waitVec($sformatf("t2_wait%0d", i / 20));
        ackVector($sformatf("t2_ack%0d", i / 20));
      end
    end

    $display("[TB] stall with acc_valid held");
    stallVec = '0;
    for (int k = 0; k < N_OUT; k++) begin
      stallVec[k*OUT_W +: OUT_W] = OUT_W'(k + 100);
      applyStimulus(longint'(k + 100) * 256, k + 100);
    end
    waitVec("t3_wait");
    bus.acc_valid = 1'b1;
    bus.acc_data  = acc_t'(777 * 256);
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("t3_stall_rdy%0d", c), longint'(bus.acc_ready), 0);
      checkVec($sformatf("t3_stall_data%0d", c), bus.vec_data, stallVec);
      @(negedge clk);
    end
    ackVector("t3");
    applyStimulus(777 * 256, 777);
    e0 = act_t'(bus.vec_data[0 +: OUT_W]);
    checkOutput("t3_e0_t+1", longint'(e0), 100);
    bus.acc_valid = 1'b0;
    @(negedge clk);
    e0 = act_t'(bus.vec_data[0 +: OUT_W]);
    checkOutput("t3_e0_t+2", longint'(e0), 777);
    e0 = act_t'(bus.vec_data[OUT_W +: OUT_W]);
    checkOutput("t3_e1_kept", longint'(e0), 101);
    for (int k = 1; k < N_OUT; k++) applyStimulus(longint'(k + 500) * 256, k + 500);
    bus.acc_valid = 1'b0;
    waitVec("t3_wait2");
    ackVector("t3b");

    $display("[TB] gapped input");
    for (int k = 0; k < N_OUT; k++) begin
      bus.acc_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(longint'(k) * 256, k);
    end
    bus.acc_valid = 1'b0;
    waitVec("t4_wait");
    ackVector("t4");

    $display("[TB] reset mid-vector");
    for (int k = 0; k < 7; k++) applyStimulus(longint'(k + 50) * 256, k + 50);
    bus.acc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_vv", longint'(bus.vec_valid), 0);
    checkOutput("t5_rdy", longint'(bus.acc_ready), 0);
    checkVec("t5_data", bus.vec_data, '0);
    expQ.delete();
    rst = 1'b0;
    @(negedge clk);
    checkVec("t5_data_after", bus.vec_data, '0);
    for (int k = 0; k < N_OUT; k++) applyStimulus(longint'(k + 200) * 256, k + 200);
    bus.acc_valid = 1'b0;
    waitVec("t5_wait");
    ackVector("t5");

    $display("[TB] nineteen transfers then idle");
    for (int k = 0; k < N_OUT - 1; k++) applyStimulus(longint'(k + 300) * 256, k + 300);
    bus.acc_valid = 1'b0;
    bus.vec_ack   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_idle_vv%0d", c), longint'(bus.vec_valid), 0);
    end
    bus.vec_ack = 1'b0;
    checkOutput("t6_idle_rdy", longint'(bus.acc_ready), 1);
    applyStimulus(319 * 256, 319);
    bus.acc_valid = 1'b0;
    checkOutput("t6_vv_t+1", longint'(bus.vec_valid), 0);
    @(negedge clk);
    checkOutput("t6_vv_t+2", longint'(bus.vec_valid), 1);
    ackVector("t6");

    repeat (3) @(negedge clk);
    checkOutput("vectors_seen", vecCount, 8);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
